// File: rtl/lut_layer_pkg.sv
// Shared types and helpers for the LUT layer engine.
package lut_layer_pkg;

    typedef enum logic [1:0] {
        CFG   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Width of the neuron select field; a single-neuron layer still gets one bit.
    function automatic int cfg_nw(input int neurons);
        return (neurons > 1) ? $clog2(neurons) : 1;
    endfunction

endpackage

// File: rtl/lut_layer_engine_if.sv
// Frame stream, result stream and configuration port of the LUT layer engine.
interface lut_layer_engine_if #(
    parameter int NEURONS  = 4,
    parameter int FAN_IN   = 6,
    parameter int OUT_BITS = 1
);
    import lut_layer_pkg::*;

    localparam int CFG_NW = cfg_nw(NEURONS);

    logic                         in_valid;
    logic                         in_ready;
    logic [NEURONS*FAN_IN-1:0]    in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [NEURONS*OUT_BITS-1:0]  out_data;
    logic                         cfg_we;
    logic [CFG_NW-1:0]            cfg_neuron;
    logic [FAN_IN-1:0]            cfg_addr;
    logic [OUT_BITS-1:0]          cfg_data;
    logic                         cfg_done;
    logic                         cfg_start;
    logic                         mode_run;
    logic                         cfg_err;

    modport master (
        output in_valid, in_data, out_ready,
        output cfg_we, cfg_neuron, cfg_addr, cfg_data, cfg_done, cfg_start,
        input  in_ready, out_valid, out_data, mode_run, cfg_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        input  cfg_we, cfg_neuron, cfg_addr, cfg_data, cfg_done, cfg_start,
        output in_ready, out_valid, out_data, mode_run, cfg_err
    );

endinterface

// File: rtl/lut_layer_engine_neuron_table.sv
// Truth-table storage for one neuron: synchronous write, combinational read.
module lut_neuron_table #(
    parameter int FAN_IN   = 6,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [FAN_IN-1:0]   waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic [FAN_IN-1:0]   raddr,
    output logic [OUT_BITS-1:0] rdata
);
    localparam int DEPTH = 2**FAN_IN;

    logic [OUT_BITS-1:0] mem_q [DEPTH];
    logic [OUT_BITS-1:0] mem_d [DEPTH];

    // Next table contents: one entry replaced on a write strobe.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Table register; reset clears every entry so a fresh layer computes all-zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_layer_engine.sv
// LUT layer engine: NEURONS runtime-loadable truth tables behind a 2-stage
// valid/ready pipeline, with a mode FSM that fences table writes from traffic.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CFG   | tables writable, no frames accepted
//   RUN   | frames flow, writes rejected with cfg_err
//   DRAIN | no new frames; leave for CFG once both stages are empty
module lut_layer_engine
    import lut_layer_pkg::*;
#(
    parameter int NEURONS  = 4,
    parameter int FAN_IN   = 6,
    parameter int OUT_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    lut_layer_engine_if.slave    bus
);
    localparam int CFG_NW = cfg_nw(NEURONS);
    localparam int IW     = NEURONS * FAN_IN;
    localparam int OW     = NEURONS * OUT_BITS;

    state_e            state_q, state_d;
    logic              s1_valid_q, s1_valid_d;
    logic [IW-1:0]     s1_addr_q, s1_addr_d;
    logic              s2_valid_q, s2_valid_d;
    logic [OW-1:0]     s2_data_q, s2_data_d;
    logic              cfg_err_q, cfg_err_d;

    logic [NEURONS-1:0] neuron_sel;
    logic [NEURONS-1:0] tbl_we;
    logic               neuron_hit;
    logic [OW-1:0]      lookup;
    logic               s1_load, s2_load, accept;

    // Configuration decode: writes only land in CFG and for an existing neuron.
    always_comb begin
        neuron_sel = '0;
        for (int n = 0; n < NEURONS; n++) begin
            neuron_sel[n] = (bus.cfg_neuron == CFG_NW'(n));
        end
        neuron_hit = |neuron_sel;
        tbl_we     = neuron_sel & {NEURONS{(state_q == CFG) && bus.cfg_we}};
    end

    generate
        for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
            lut_neuron_table #(
                .FAN_IN   (FAN_IN),
                .OUT_BITS (OUT_BITS)
            ) u_table (
                .clk   (clk),
                .rst   (rst),
                .we    (tbl_we[n]),
                .waddr (bus.cfg_addr),
                .wdata (bus.cfg_data),
                .raddr (s1_addr_q[n*FAN_IN +: FAN_IN]),
                .rdata (lookup[n*OUT_BITS +: OUT_BITS])
            );
        end
    endgenerate

    // Pipeline advance: a stage loads when empty or when its contents move on,
    // so ready ripples back combinationally and a full pipe still streams.
    always_comb begin
        s2_load    = !s2_valid_q || bus.out_ready;
        s1_load    = !s1_valid_q || s2_load;
        accept     = bus.in_valid && (state_q == RUN) && s1_load;

        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;

        if (s1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_addr_d = bus.in_data;
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = lookup;
            end
        end
    end

    // Mode FSM next state and write-rejection flag. DRAIN looks at the next
    // occupancy so it can exit in the same cycle the last result hands off.
    always_comb begin
        state_d   = state_q;
        cfg_err_d = 1'b0;
        case (state_q)
            CFG: begin
                cfg_err_d = bus.cfg_we && !neuron_hit;
                if (bus.cfg_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cfg_err_d = bus.cfg_we;
                if (bus.cfg_start) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cfg_err_d = bus.cfg_we;
                if (!s1_valid_d && !s2_valid_d) begin
                    state_d = CFG;
                end
            end
            default: begin
                state_d = CFG;
            end
        endcase
    end

    // State, pipeline and error-pulse registers; reset discards in-flight frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CFG;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bus.in_ready  = (state_q == RUN) && s1_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.mode_run  = (state_q == RUN);
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_engine.sv
// Self-checking bench for lut_layer_engine against a table/queue reference model.
module tb_lut_layer_engine;
    import lut_layer_pkg::*;

    localparam int N     = 4;
    localparam int F     = 6;
    localparam int B     = 1;
    localparam int IW    = N * F;
    localparam int OW    = N * B;
    localparam int DEPTH = 2**F;
    localparam int CNW   = cfg_nw(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_layer_engine_if #(.NEURONS(N), .FAN_IN(F), .OUT_BITS(B)) bus ();

    lut_layer_engine #(.NEURONS(N), .FAN_IN(F), .OUT_BITS(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: table contents plus the ordered results still owed.
    logic [B-1:0]  model_tbl [N][DEPTH];
    logic [OW-1:0] exp_q [$];

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    logic acc, ohs;
    int   occ;

    function automatic logic [OW-1:0] model_eval(input logic [IW-1:0] d);
        logic [OW-1:0] r;
        r = '0;
        for (int n = 0; n < N; n++) r[n*B +: B] = model_tbl[n][d[n*F +: F]];
        return r;
    endfunction

    function automatic logic [IW-1:0] rand_frame();
        return IW'({$urandom(), $urandom()});
    endfunction

    // One cycle of traffic: drive at the falling edge, observe 1 time unit later.
    task automatic drive_cycle(input logic v, input logic [IW-1:0] d, input logic ordy, input logic start);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.cfg_start = start;
        bus.cfg_we    = 1'b0;
        bus.cfg_done  = 1'b0;
        #1;
        occ = exp_q.size();
        acc = bus.in_valid && bus.in_ready;
        ohs = bus.out_valid && bus.out_ready;
        if (acc) exp_q.push_back(model_eval(d));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        bus.cfg_we = 0; bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.cfg_done = 0; bus.cfg_start = 0;
        for (int n = 0; n < N; n++) for (int a = 0; a < DEPTH; a++) model_tbl[n][a] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.out_data !== '0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else pass_cnt++;
        chk_cnt++; if (bus.mode_run !== 1'b0) $display("FAIL reset_mode_run: got %b want 0", bus.mode_run); else pass_cnt++;
        chk_cnt++; if (bus.cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b want 0", bus.cfg_err); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Neuron 0: output high when both top address bits are set; others: address bit 0.
    task automatic test_program();
        for (int n = 0; n < N; n++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [F-1:0] av;
                logic [B-1:0] v;
                av = F'(a);
                v  = (n == 0) ? B'(av[F-1] & av[F-2]) : B'(av[0]);
                @(negedge clk);
                bus.cfg_we = 1'b1; bus.cfg_neuron = CNW'(n); bus.cfg_addr = av; bus.cfg_data = v;
                model_tbl[n][a] = v;
            end
        end
        @(negedge clk);
        bus.cfg_we = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL cfg_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
        chk_cnt++; if (bus.cfg_err !== 1'b0) $display("FAIL cfg_write_err: got %b want 0", bus.cfg_err); else pass_cnt++;
        bus.in_valid = 1'b0;
        bus.cfg_done = 1'b1;
        #1;
        chk_cnt++; if (bus.mode_run !== 1'b0) $display("FAIL done_early_run: got %b want 0", bus.mode_run); else pass_cnt++;
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk_cnt++; if (bus.mode_run !== 1'b1) $display("FAIL done_mode_run: got %b want 1", bus.mode_run); else pass_cnt++;
        chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL done_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_stream();
        int first_acc = -1, first_ov = -1, got = 0;
        logic [OW-1:0] e;
        for (int c = 0; c < 70; c++) begin
            logic [IW-1:0] d;
            d = rand_frame();
            d[F-1:0] = F'(c);
            drive_cycle(c < 64, d, 1'b1, 1'b0);
            if (acc && first_acc < 0) first_acc = c;
            if (bus.out_valid && first_ov < 0) first_ov = c;
            if (ohs) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL stream_extra: got %h want none", bus.out_data);
                else begin
                    e = exp_q.pop_front(); got++;
                    if (bus.out_data !== e) $display("FAIL stream_data: got %h want %h", bus.out_data, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (first_ov - first_acc != 2) $display("FAIL stream_latency: got %0d want 2", first_ov - first_acc); else pass_cnt++;
        chk_cnt++; if (got != 64 || exp_q.size() != 0) $display("FAIL stream_count: got %0d want 64", got); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] d;
        logic [OW-1:0] held, e;
        logic ordy, held_ok, er;
        int sent = 0, got = 0;
        d = rand_frame();
        held_ok = 1'b0;
        held = '0;
        for (int c = 0; c < 40; c++) begin
            ordy = !(c >= 8 && c < 13);
            drive_cycle(sent < 20, d, ordy, 1'b0);
            er = (occ < 2) || ordy;
            chk_cnt++; if (bus.in_ready !== er) $display("FAIL bp_in_ready: cycle %0d got %b want %b", c, bus.in_ready, er); else pass_cnt++;
            if (!ordy) begin
                if (!held_ok) begin
                    held = bus.out_data; held_ok = bus.out_valid;
                end else begin
                    chk_cnt++;
                    if (bus.out_data !== held || bus.out_valid !== 1'b1)
                        $display("FAIL bp_hold: got %h/%b want %h/1", bus.out_data, bus.out_valid, held);
                    else pass_cnt++;
                end
            end
            if (acc) begin sent++; d = rand_frame(); end
            if (ohs) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL bp_extra: got %h want none", bus.out_data);
                else begin
                    e = exp_q.pop_front(); got++;
                    if (bus.out_data !== e) $display("FAIL bp_data: got %h want %h", bus.out_data, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (got != 20 || sent != 20 || exp_q.size() != 0) $display("FAIL bp_count: got %0d sent %0d want 20", got, sent); else pass_cnt++;
    endtask

    task automatic test_random_throttle();
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        logic ordy, v, er;
        int sent = 0, got = 0;
        d = rand_frame();
        for (int c = 0; c < 110; c++) begin
            ordy = (c >= 80) || ($urandom_range(0, 9) < 7);
            v    = (sent < 30) && ($urandom_range(0, 1) == 1);
            drive_cycle(v, d, ordy, 1'b0);
            er = (occ < 2) || ordy;
            chk_cnt++; if (bus.in_ready !== er) $display("FAIL thr_in_ready: cycle %0d got %b want %b", c, bus.in_ready, er); else pass_cnt++;
            if (acc) begin sent++; d = rand_frame(); end
            if (ohs) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL thr_extra: got %h want none", bus.out_data);
                else begin
                    e = exp_q.pop_front(); got++;
                    if (bus.out_data !== e) $display("FAIL thr_data: got %h want %h", bus.out_data, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (got != sent || exp_q.size() != 0) $display("FAIL thr_count: got %0d want %0d", got, sent); else pass_cnt++;
    endtask

    task automatic test_cfg_we_run();
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        int got = 0;
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        bus.cfg_we = 1'b1; bus.cfg_neuron = CNW'(1); bus.cfg_addr = F'(3); bus.cfg_data = ~model_tbl[1][3];
        #1;
        chk_cnt++; if (bus.cfg_err !== 1'b0) $display("FAIL run_we_err_early: got %b want 0", bus.cfg_err); else pass_cnt++;
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk_cnt++; if (bus.cfg_err !== 1'b1) $display("FAIL run_we_err: got %b want 1", bus.cfg_err); else pass_cnt++;
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk_cnt++; if (bus.cfg_err !== 1'b0) $display("FAIL run_we_err_pulse: got %b want 0", bus.cfg_err); else pass_cnt++;
        d = rand_frame();
        d[F +: F] = F'(3);
        for (int c = 0; c < 6; c++) begin
            drive_cycle(c == 0, d, 1'b1, 1'b0);
            if (ohs) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL run_we_extra: got %h want none", bus.out_data);
                else begin
                    e = exp_q.pop_front(); got++;
                    if (bus.out_data !== e) $display("FAIL run_we_lookup: got %h want %h", bus.out_data, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (got != 1) $display("FAIL run_we_count: got %0d want 1", got); else pass_cnt++;
    endtask

    task automatic test_drain();
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        logic [B-1:0]  nv;
        int got = 0;
        drive_cycle(1'b1, rand_frame(), 1'b1, 1'b0);
        chk_cnt++; if (acc !== 1'b1) $display("FAIL drain_acc_a: got %b want 1", acc); else pass_cnt++;
        drive_cycle(1'b1, rand_frame(), 1'b1, 1'b1);
        chk_cnt++; if (acc !== 1'b1) $display("FAIL drain_acc_b: got %b want 1", acc); else pass_cnt++;
        for (int c = 2; c <= 5; c++) begin
            drive_cycle(c < 5, rand_frame(), 1'b1, 1'b0);
            chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL drain_in_ready: cycle %0d got %b want 0", c, bus.in_ready); else pass_cnt++;
            chk_cnt++; if (bus.mode_run !== 1'b0) $display("FAIL drain_mode_run: cycle %0d got %b want 0", c, bus.mode_run); else pass_cnt++;
            chk_cnt++; if (ohs !== (c == 2 || c == 3)) $display("FAIL drain_handoff: cycle %0d got %b want %b", c, ohs, (c == 2 || c == 3)); else pass_cnt++;
            if (ohs && exp_q.size() != 0) begin
                e = exp_q.pop_front(); got++;
                chk_cnt++; if (bus.out_data !== e) $display("FAIL drain_data: got %h want %h", bus.out_data, e); else pass_cnt++;
            end
            if (c == 3) begin
                bus.cfg_we = 1'b1; bus.cfg_neuron = CNW'(2); bus.cfg_addr = F'(5); bus.cfg_data = model_tbl[2][5];
            end
            if (c == 4) begin
                chk_cnt++; if (bus.cfg_err !== 1'b1) $display("FAIL drain_still_drain: got %b want 1", bus.cfg_err); else pass_cnt++;
                nv = ~model_tbl[2][5];
                bus.cfg_we = 1'b1; bus.cfg_neuron = CNW'(2); bus.cfg_addr = F'(5); bus.cfg_data = nv;
                model_tbl[2][5] = nv;
            end
            if (c == 5) begin
                chk_cnt++; if (bus.cfg_err !== 1'b0) $display("FAIL drain_reached_cfg: got %b want 0", bus.cfg_err); else pass_cnt++;
                bus.cfg_done = 1'b1;
            end
        end
        chk_cnt++; if (got != 2 || exp_q.size() != 0) $display("FAIL drain_count: got %0d want 2", got); else pass_cnt++;
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk_cnt++; if (bus.mode_run !== 1'b1) $display("FAIL drain_rerun: got %b want 1", bus.mode_run); else pass_cnt++;
        d = rand_frame();
        d[2*F +: F] = F'(5);
        for (int c = 0; c < 5; c++) begin
            drive_cycle(c == 0, d, 1'b1, 1'b0);
            if (ohs) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL drain_extra: got %h want none", bus.out_data);
                else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) $display("FAIL drain_new_entry: got %h want %h", bus.out_data, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL drain_lost: got %0d pending want 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        int got = 0;
        d = rand_frame();
        d[F +: F] = F'(1);
        drive_cycle(1'b1, d, 1'b0, 1'b0);
        drive_cycle(1'b1, rand_frame(), 1'b0, 1'b0);
        drive_cycle(1'b1, rand_frame(), 1'b0, 1'b0);
        chk_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data === '0) $display("FAIL rst_pre_full: got %b/%h want 1/nonzero", bus.out_valid, bus.out_data); else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_async_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.out_data !== '0) $display("FAIL rst_async_out_data: got %h want 0", bus.out_data); else pass_cnt++;
        chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rst_async_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
        chk_cnt++; if (bus.mode_run !== 1'b0) $display("FAIL rst_async_mode_run: got %b want 0", bus.mode_run); else pass_cnt++;
        exp_q.delete();
        for (int n = 0; n < N; n++) for (int a = 0; a < DEPTH; a++) model_tbl[n][a] = '0;
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, rand_frame(), 1'b1, 1'b0);
        chk_cnt++; if (bus.mode_run !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL rst_cfg_state: got %b/%b want 0/0", bus.mode_run, bus.in_ready); else pass_cnt++;
        bus.cfg_done = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drive_cycle(c < 8, rand_frame(), 1'b1, 1'b0);
            if (ohs) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL rst_extra: got %h want none", bus.out_data);
                else begin
                    e = exp_q.pop_front(); got++;
                    if (bus.out_data !== e) $display("FAIL rst_cleared_lookup: got %h want %h", bus.out_data, e); else pass_cnt++;
                end
            end
        end
        chk_cnt++; if (got != 8) $display("FAIL rst_count: got %0d want 8", got); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_program();
        test_stream();
        test_backpressure();
        test_random_throttle();
        test_cfg_we_run();
        test_drain();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
